obi_to_apb_bridge: RTL and testbench
====================================

Name: obi_to_apb_bridge

Overview:
- Single-outstanding bridge: OBI subordinate port in, APB4 manager port out.
- Sits between an OBI interconnect and APB register blocks such as the iDMA register file.
- Each accepted OBI request becomes exactly one APB transfer (SETUP then ACCESS).
- Each transfer returns exactly one OBI response carrying the read data and the error flag.

Parameters:
- ADDR_WIDTH, 8: OBI/APB address width.
- DATA_WIDTH, 32: data width; must be a multiple of 8.
- ID_WIDTH, 1: OBI transaction ID width.
- PPROT_VAL, 3'b000: constant driven on pprot.
- TIMEOUT_CYCLES, 255: ACCESS-phase wait limit; used only when OBI_TO_APB_TIMEOUT_EN is defined.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- obi_req_i  in  1  OBI request.
- obi_gnt_o  out  1  OBI grant.
- obi_addr_i  in  ADDR_WIDTH  byte address.
- obi_we_i  in  1  1=write.
- obi_be_i  in  DATA_WIDTH/8  byte enables.
- obi_wdata_i  in  DATA_WIDTH  write data.
- obi_aid_i  in  ID_WIDTH  request ID.
- obi_rvalid_o  out  1  response valid.
- obi_rdata_o  out  DATA_WIDTH  read data.
- obi_rid_o  out  ID_WIDTH  response ID.
- obi_err_o  out  1  response error.
- apb_psel_o  out  1  APB select.
- apb_penable_o  out  1  APB enable.
- apb_pwrite_o  out  1  APB write.
- apb_pprot_o  out  3  APB protection.
- apb_paddr_o  out  ADDR_WIDTH  APB address.
- apb_pwdata_o  out  DATA_WIDTH  APB write data.
- apb_pstrb_o  out  DATA_WIDTH/8  APB strobes.
- apb_pready_i  in  1  APB ready.
- apb_prdata_i  in  DATA_WIDTH  APB read data.
- apb_pslverr_i  in  1  APB error.

Behaviour:
- States and transitions:
  - IDLE: obi_gnt_o = obi_req_i (combinational). On req&gnt, latch addr, we, be, wdata and aid, then go to SETUP. No grant in any other state.
  - SETUP: psel=1, penable=0. Unconditionally go to ACCESS.
  - ACCESS: psel=1, penable=1. Hold all APB outputs stable. When pready=1, register prdata and pslverr, then go to RESP.
  - RESP: obi_rvalid_o=1 for exactly one cycle. Then go to IDLE. No rready; the OBI side must accept the response.
- APB output values (all registered; no combinational path from OBI inputs to APB outputs):
  - paddr = latched addr, unmodified (no alignment change).
  - pwrite = latched we.
  - pwdata = latched wdata.
  - pstrb = latched be on writes, all-zero on reads.
  - pprot = PPROT_VAL.
- OBI response values:
  - rdata = captured prdata on reads, 0 on writes.
  - err = captured pslverr.
  - rid = latched aid.
- Latency: grant in cycle 0, SETUP in cycle 1, ACCESS in cycle 2, rvalid in cycle 2+N+1, where N = pready wait cycles. Back-to-back minimum is 4 cycles per transaction.
- apb_pready_i, apb_prdata_i and apb_pslverr_i are ignored outside ACCESS.
- Reset values: state IDLE; psel, penable, pwrite, paddr, pwdata, pstrb all 0; rvalid, rdata, rid, err all 0.
- Reset asserted mid-transfer aborts immediately. No response is issued.

Optional Feature:
- Macro: OBI_TO_APB_TIMEOUT_EN.
- When defined:
  - A counter runs in ACCESS and is cleared on entry to ACCESS.
  - If TIMEOUT_CYCLES cycles elapse without pready, the bridge deasserts psel/penable, goes to RESP and returns err=1, rdata=0.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- When undefined: no counter logic; ACCESS waits on pready indefinitely.

Decomposition:
- Package obi_to_apb_pkg holds:
  - state enum state_e {IDLE, SETUP, ACCESS, RESP};
  - the latched-request struct {addr, we, be, wdata, aid};
  - the default PPROT constant.
- No sub-module is needed; a single FSM module suffices.

Test Plan:
- Write, zero-wait: addr 0x10, wdata 0xDEADBEEF, be 0xF, aid 1, pready=1.
  -> SETUP then ACCESS with paddr=0x10, pwrite=1, pstrb=0xF; rvalid 3 cycles after gnt with rid=1, err=0, rdata=0.
- Read, 2 wait cycles: addr 0x04, prdata=0x12345678 presented with pready on the third ACCESS cycle.
  -> pstrb=0; rdata=0x12345678; rvalid at cycle 5.
- Slave error: write to 0xFC with pslverr=1 -> err=1, rvalid once, next request granted afterwards.
- Back-to-back: req held high for two writes -> second gnt only after RESP; exactly two APB transfers; no overlap.
- Reset mid-ACCESS: rst_ni low while penable=1 -> psel, penable and rvalid go 0 asynchronously; no response follows.
- Timeout (OBI_TO_APB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8): pready held 0 -> after 8 ACCESS cycles, rvalid with err=1, rdata=0.

Source files
------------

// File: rtl/obi_to_apb_pkg.sv
// Shared types and constants for the OBI-to-APB4 bridge.
package obi_to_apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  localparam logic [2:0] PPROT_DEFAULT = 3'b000;

  localparam int unsigned ADDR_WIDTH_DEFAULT = 8;
  localparam int unsigned DATA_WIDTH_DEFAULT = 32;
  localparam int unsigned ID_WIDTH_DEFAULT   = 1;

  // Latched OBI request at the default widths; the bridge declares a
  // width-parameterised twin since packages cannot take parameters.
  typedef struct packed {
    logic [ADDR_WIDTH_DEFAULT-1:0]   addr;
    logic                            we;
    logic [DATA_WIDTH_DEFAULT/8-1:0] be;
    logic [DATA_WIDTH_DEFAULT-1:0]   wdata;
    logic [ID_WIDTH_DEFAULT-1:0]     aid;
  } obi_req_t;

endpackage

// File: rtl/obi_to_apb_bridge.sv
// Single-outstanding OBI subordinate to APB4 manager bridge.
// Optional ACCESS-phase timeout enabled by defining OBI_TO_APB_TIMEOUT_EN.
module obi_to_apb_bridge
  import obi_to_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEFAULT,
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int unsigned ID_WIDTH       = ID_WIDTH_DEFAULT,
  parameter logic [2:0]  PPROT_VAL      = PPROT_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    obi_req_i,
  output logic                    obi_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
  input  logic                    obi_we_i,
  input  logic [DATA_WIDTH/8-1:0] obi_be_i,
  input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
  input  logic [ID_WIDTH-1:0]     obi_aid_i,
  output logic                    obi_rvalid_o,
  output logic [DATA_WIDTH-1:0]   obi_rdata_o,
  output logic [ID_WIDTH-1:0]     obi_rid_o,
  output logic                    obi_err_o,
  output logic                    apb_psel_o,
  output logic                    apb_penable_o,
  output logic                    apb_pwrite_o,
  output logic [2:0]              apb_pprot_o,
  output logic [ADDR_WIDTH-1:0]   apb_paddr_o,
  output logic [DATA_WIDTH-1:0]   apb_pwdata_o,
  output logic [DATA_WIDTH/8-1:0] apb_pstrb_o,
  input  logic                    apb_pready_i,
  input  logic [DATA_WIDTH-1:0]   apb_prdata_i,
  input  logic                    apb_pslverr_i
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  if ((DATA_WIDTH == 0) || (DATA_WIDTH % 8 != 0)) begin : g_bad_data_width
    $error("DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [STRB_WIDTH-1:0] be;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ID_WIDTH-1:0]   aid;
  } req_t;

  state_e                state_q, state_d;
  req_t                  req_q;
  logic                  rsp_en;
  logic                  rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  timeout;

`ifdef OBI_TO_APB_TIMEOUT_EN
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_WIDTH-1:0] cnt_q;

  // Fires on the last permitted ACCESS cycle that still lacks pready.
  assign timeout = (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q == SETUP) begin
      cnt_q <= '0;
    end else if ((state_q == ACCESS) && !timeout) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    obi_gnt_o   = 1'b0;
    rsp_en      = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    unique case (state_q)
      IDLE: begin
        obi_gnt_o = obi_req_i;
        if (obi_req_i) state_d = SETUP;
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (apb_pready_i) begin
          state_d     = RESP;
          rsp_en      = 1'b1;
          rsp_err_d   = apb_pslverr_i;
          rsp_rdata_d = req_q.we ? '0 : apb_prdata_i;
        end else if (timeout) begin
          state_d   = RESP;
          rsp_en    = 1'b1;
          rsp_err_d = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q <= '0;
    end else if ((state_q == IDLE) && obi_req_i) begin
      req_q.addr  <= obi_addr_i;
      req_q.we    <= obi_we_i;
      req_q.be    <= obi_be_i;
      req_q.wdata <= obi_wdata_i;
      req_q.aid   <= obi_aid_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (rsp_en) begin
      rdata_q <= rsp_rdata_d;
      err_q   <= rsp_err_d;
    end
  end

  // APB outputs decode only from flops, never from OBI inputs.
  assign apb_psel_o    = (state_q == SETUP) || (state_q == ACCESS);
  assign apb_penable_o = (state_q == ACCESS);
  assign apb_pwrite_o  = req_q.we;
  assign apb_pprot_o   = PPROT_VAL;
  assign apb_paddr_o   = req_q.addr;
  assign apb_pwdata_o  = req_q.wdata;
  assign apb_pstrb_o   = req_q.we ? req_q.be : '0;

  assign obi_rvalid_o = (state_q == RESP);
  assign obi_rdata_o  = rdata_q;
  assign obi_rid_o    = req_q.aid;
  assign obi_err_o    = err_q;

endmodule

// File: tb/tb_obi_to_apb_bridge.sv
// Scoreboard bench for obi_to_apb_bridge: directed OBI requests, reactive APB slave.
module tb_obi_to_apb_bridge;

  localparam logic [2:0] PPROT = 3'b010;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        obi_req;
  logic        obi_gnt_o;
  logic [7:0]  obi_addr;
  logic        obi_we;
  logic [3:0]  obi_be;
  logic [31:0] obi_wdata;
  logic [0:0]  obi_aid;
  logic        obi_rvalid_o;
  logic [31:0] obi_rdata_o;
  logic [0:0]  obi_rid_o;
  logic        obi_err_o;
  logic        apb_psel_o;
  logic        apb_penable_o;
  logic        apb_pwrite_o;
  logic [2:0]  apb_pprot_o;
  logic [7:0]  apb_paddr_o;
  logic [31:0] apb_pwdata_o;
  logic [3:0]  apb_pstrb_o;
  logic        apb_pready  = 1'b0;
  logic [31:0] apb_prdata  = '0;
  logic        apb_pslverr = 1'b0;

  obi_to_apb_bridge #(
    .ADDR_WIDTH    (8),
    .DATA_WIDTH    (32),
    .ID_WIDTH      (1),
    .PPROT_VAL     (PPROT),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .obi_req_i    (obi_req),
    .obi_gnt_o    (obi_gnt_o),
    .obi_addr_i   (obi_addr),
    .obi_we_i     (obi_we),
    .obi_be_i     (obi_be),
    .obi_wdata_i  (obi_wdata),
    .obi_aid_i    (obi_aid),
    .obi_rvalid_o (obi_rvalid_o),
    .obi_rdata_o  (obi_rdata_o),
    .obi_rid_o    (obi_rid_o),
    .obi_err_o    (obi_err_o),
    .apb_psel_o   (apb_psel_o),
    .apb_penable_o(apb_penable_o),
    .apb_pwrite_o (apb_pwrite_o),
    .apb_pprot_o  (apb_pprot_o),
    .apb_paddr_o  (apb_paddr_o),
    .apb_pwdata_o (apb_pwdata_o),
    .apb_pstrb_o  (apb_pstrb_o),
    .apb_pready_i (apb_pready),
    .apb_prdata_i (apb_prdata),
    .apb_pslverr_i(apb_pslverr)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
    int          gcyc;
    int          lat;
  } rsp_t;

  typedef struct {
    logic [7:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } apb_t;

  typedef struct {
    int          waits;
    logic [31:0] prdata;
    logic        err;
  } slv_t;

  rsp_t rsp_q[$];
  apb_t apb_q[$];
  slv_t slv_q[$];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int setups  = 0;
  int grants  = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Response monitor: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    rsp_t e;
    if (rst_ni && obi_rvalid_o) begin
      if (rsp_q.size() == 0) begin
        check("unexpected_rvalid", 128'd1, 128'd0);
      end else begin
        e = rsp_q.pop_front();
        check("rsp_rdata", obi_rdata_o, e.rdata);
        check("rsp_rid", obi_rid_o, e.rid);
        check("rsp_err", obi_err_o, e.err);
        check("rsp_latency", cyc - e.gcyc, e.lat);
      end
    end
  end

  // APB monitor: SETUP contents, SETUP->ACCESS sequencing, ACCESS stability, grant exclusivity.
  logic [47:0] apb_snap;
  logic        expect_access = 1'b0;
  always @(negedge clk_i) begin
    apb_t a;
    if (rst_ni) begin
      if (expect_access) begin
        check("apb_setup_to_access", {apb_psel_o, apb_penable_o}, 2'b11);
        expect_access = 1'b0;
      end
      if (apb_psel_o && !apb_penable_o) begin
        setups++;
        expect_access = 1'b1;
        apb_snap = {apb_paddr_o, apb_pwrite_o, apb_pwdata_o, apb_pstrb_o, apb_pprot_o};
        if (apb_q.size() == 0) begin
          check("unexpected_apb_setup", 128'd1, 128'd0);
        end else begin
          a = apb_q.pop_front();
          check("apb_setup", apb_snap, {a.addr, a.we, a.wdata, a.strb, PPROT});
        end
      end else if (apb_psel_o && apb_penable_o) begin
        check("apb_access_stable",
              {apb_paddr_o, apb_pwrite_o, apb_pwdata_o, apb_pstrb_o, apb_pprot_o}, apb_snap);
      end
      if (obi_gnt_o) check("gnt_only_when_idle", {apb_psel_o, obi_rvalid_o}, 2'b00);
    end else begin
      expect_access = 1'b0;
    end
  end

  // APB slave: drives misleading values outside ACCESS, inserts wait states inside.
  slv_t slv_cur;
  logic slv_have = 1'b0;
  int   slv_acc  = 0;
  always @(negedge clk_i) begin
    if (apb_psel_o && apb_penable_o) begin
      if (!slv_have) begin
        if (slv_q.size() > 0) slv_cur = slv_q.pop_front();
        else                  slv_cur = '{0, 32'h0, 1'b0};
        slv_have = 1'b1;
        slv_acc  = 0;
      end
      if (slv_acc == slv_cur.waits) begin
        apb_pready  = 1'b1;
        apb_prdata  = slv_cur.prdata;
        apb_pslverr = slv_cur.err;
      end else begin
        apb_pready  = 1'b0;
        apb_prdata  = 32'hBADC0DE0;
        apb_pslverr = 1'b1;
      end
      slv_acc++;
    end else begin
      slv_have    = 1'b0;
      apb_pready  = 1'b1;
      apb_prdata  = 32'hBADBADBA;
      apb_pslverr = 1'b1;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the grant edge.
  task automatic issue(input logic [7:0] addr, input logic we, input logic [3:0] be,
                       input logic [31:0] wdata, input logic aid, input int waits,
                       input logic [31:0] prdata, input logic slverr,
                       input logic [3:0] exp_strb, input logic [31:0] exp_rdata,
                       input logic exp_err, input int exp_lat, input logic keep,
                       output int gcyc);
    logic got = 1'b0;
    slv_q.push_back('{waits, prdata, slverr});
    obi_req   = 1'b1;
    obi_addr  = addr;
    obi_we    = we;
    obi_be    = be;
    obi_wdata = wdata;
    obi_aid   = aid;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk_i);
      if (obi_gnt_o) got = 1'b1;
    end
    if (!got) begin
      check("gnt_timeout", 128'd0, 128'd1);
      obi_req = 1'b0;
      void'(slv_q.pop_back());
      gcyc = -1;
      return;
    end
    gcyc = cyc;
    grants++;
    rsp_q.push_back('{exp_rdata, aid, exp_err, cyc, exp_lat});
    apb_q.push_back('{addr, we, wdata, exp_strb});
    @(posedge clk_i);
    #1;
    if (!keep) obi_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && rsp_q.size() != 0; i++) @(posedge clk_i);
    check("drain_outstanding", rsp_q.size(), 0);
    rsp_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g1, g2;
    logic found;
    rst_ni    = 1'b0;
    obi_req   = 1'b0;
    obi_addr  = '0;
    obi_we    = 1'b0;
    obi_be    = '0;
    obi_wdata = '0;
    obi_aid   = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_outputs",
          {obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_rid_o, obi_err_o, apb_psel_o,
           apb_penable_o, apb_pwrite_o, apb_paddr_o, apb_pwdata_o, apb_pstrb_o}, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // addr  we be    wdata         aid waits prdata        slverr strb  rdata         err lat keep
    issue(8'h10, 1, 4'hF, 32'hDEADBEEF, 1, 0, 32'hCAFEF00D, 0, 4'hF, 32'h00000000, 0, 3, 0, g1);
    drain();
    issue(8'h04, 0, 4'hF, 32'h55555555, 0, 2, 32'h12345678, 0, 4'h0, 32'h12345678, 0, 5, 0, g1);
    drain();
    issue(8'hFC, 1, 4'h3, 32'h0000ABCD, 1, 1, 32'h11112222, 1, 4'h3, 32'h00000000, 1, 4, 0, g1);
    drain();
    issue(8'h30, 0, 4'h1, 32'h00000000, 0, 0, 32'hA5A5A5A5, 1, 4'h0, 32'hA5A5A5A5, 1, 3, 0, g1);
    drain();

    issue(8'h20, 1, 4'hF, 32'h01020304, 0, 0, 32'h0, 0, 4'hF, 32'h0, 0, 3, 1, g1);
    issue(8'h24, 1, 4'hC, 32'hA0B0C0D0, 1, 0, 32'h0, 0, 4'hC, 32'h0, 0, 3, 0, g2);
    check("b2b_gnt_spacing", g2 - g1, 4);
    drain();

    // Abort a read stalled in ACCESS; its expectation is withdrawn.
    issue(8'h08, 0, 4'hF, 32'h0, 1, 20, 32'h77777777, 0, 4'h0, 32'h77777777, 0, 23, 0, g1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk_i);
      if (apb_psel_o && apb_penable_o) found = 1'b1;
    end
    check("abort_reached_access", found, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("abort_async_clear", {apb_psel_o, apb_penable_o, obi_rvalid_o}, 3'b000);
    check("abort_rsp_regs_reset", {obi_rdata_o, obi_rid_o, obi_err_o}, '0);
    void'(rsp_q.pop_back());
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (8) @(posedge clk_i);
    #1;
    check("abort_no_response", rsp_q.size(), 0);

    issue(8'h80, 0, 4'h1, 32'h11111111, 0, 3, 32'h0F0F0F0F, 0, 4'h0, 32'h0F0F0F0F, 0, 6, 0, g1);
    drain();

`ifdef OBI_TO_APB_TIMEOUT_EN
    issue(8'h40, 0, 4'hF, 32'h0, 1, 100, 32'h99999999, 0, 4'h0, 32'h00000000, 1, 10, 0, g1);
    drain();
`endif

    check("apb_transfer_count", setups, grants);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
